key_event: RTL and testbench

Per-key press classifier sitting directly downstream of the key debouncer. Consumes the debouncer's 6-bit debounced level vector (idle high, pressed low) and turns each key's level into one-cycle event pulses: press, release, long-press and optional auto-repeat. A priority encoder also presents one compact event per cycle to the menu/UI logic.

---
 rtl/key_event_if.sv | 33 +++
 rtl/key_event.sv | 179 +++++++++++++++++
 tb/tb_key_event.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/key_event_if.sv
`timescale 1ns/1ps
// key_event_if: groups the debounced key levels and every classifier output.
// Handshake: evt_vld is a one-cycle strobe with no ready/backpressure; the
// consumer must capture evt_key/evt_type in the cycle evt_vld is high, and
// the per-key bit vectors are likewise single-cycle pulses that are never held.
// Note: "release" and "repeat" are SV keywords, so those vectors are named
// key_release and key_repeat.
interface key_event_if #(
    parameter int KEY_W = 6
);
    logic [KEY_W-1:0]   shape;
    logic [KEY_W-1:0]   press;
    logic [KEY_W-1:0]   key_release;
    logic [KEY_W-1:0]   long_press;
    logic [KEY_W-1:0]   key_repeat;
    logic [KEY_W-1:0]   held;
    logic               evt_vld;
    logic [2:0]         evt_key;
    logic [1:0]         evt_type;
    logic [2*KEY_W-1:0] dbg_state;

    modport master (
        output shape,
        input  press, key_release, long_press, key_repeat, held,
        input  evt_vld, evt_key, evt_type, dbg_state
    );

    modport slave (
        input  shape,
        output press, key_release, long_press, key_repeat, held,
        output evt_vld, evt_key, evt_type, dbg_state
    );
endinterface

// File: rtl/key_event.sv
`timescale 1ns/1ps
// key_event: per-key classifier downstream of the debouncer. Turns each key's
// debounced level (1 = released, 0 = pressed) into press / release /
// long-press / auto-repeat pulses, and priority-encodes one event per cycle.
// Optional feature macro: KEY_EVENT_REPEAT_EN compiles in auto-repeat; when
// undefined key_repeat is constant 0 and the LONG state parks its counter.
// dbg_state carries each key's FSM state, two bits per key (key i at [2i+1:2i]).
module key_event #(
    parameter int KEY_W    = 6,
    parameter int LONG_CNT = 25_000_000,
    parameter int REP_CNT  = 5_000_000
) (
    input logic        clk,
    input logic        rst,
    key_event_if.slave bus
);
    // The counter must hold the longer of the two periods.
    localparam int CNT_MAX = (REP_CNT > LONG_CNT) ? REP_CNT : LONG_CNT;
    localparam int CW      = $clog2(CNT_MAX + 1);
    // Compare against period-1 so the pulse fires on the edge that completes
    // the period (long fires after edge k+LONG_CNT-1).
    localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CNT - 1);
`ifdef KEY_EVENT_REPEAT_EN
    localparam logic [CW-1:0] REP_LAST  = CW'(REP_CNT - 1);
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HELD = 2'd1,
        LONG = 2'd2
    } key_state_t;

    key_state_t       state_q [KEY_W];
    key_state_t       state_n [KEY_W];
    logic [CW-1:0]    cnt_q   [KEY_W];
    logic [CW-1:0]    cnt_n   [KEY_W];
    logic [KEY_W-1:0] shape_d;
    logic [KEY_W-1:0] press_q, press_n;
    logic [KEY_W-1:0] rel_q, rel_n;
    logic [KEY_W-1:0] long_q, long_n;
    logic [KEY_W-1:0] rep_q, rep_n;
    logic             enc_vld;
    logic [2:0]       enc_key;
    logic [1:0]       enc_type;
    logic             evt_vld_q;
    logic [2:0]       evt_key_q;
    logic [1:0]       evt_type_q;

    // Per-key next state, counter and event pulses; release beats long/repeat.
    always_comb begin
        press_n = '0;
        rel_n   = '0;
        long_n  = '0;
        rep_n   = '0;
        for (int i = 0; i < KEY_W; i++) begin
            state_n[i] = state_q[i];
            cnt_n[i]   = cnt_q[i];
            case (state_q[i])
                IDLE: begin
                    cnt_n[i] = '0;
                    if (shape_d[i] && !bus.shape[i]) begin
                        state_n[i] = HELD;
                        press_n[i] = 1'b1;
                        cnt_n[i]   = CW'(1);
                    end
                end
                HELD: begin
                    if (bus.shape[i]) begin
                        state_n[i] = IDLE;
                        rel_n[i]   = 1'b1;
                        cnt_n[i]   = '0;
                    end else if (cnt_q[i] == LONG_LAST) begin
                        state_n[i] = LONG;
                        long_n[i]  = 1'b1;
                        cnt_n[i]   = '0;
                    end else begin
                        cnt_n[i] = cnt_q[i] + CW'(1);
                    end
                end
                LONG: begin
                    if (bus.shape[i]) begin
                        state_n[i] = IDLE;
                        rel_n[i]   = 1'b1;
                        cnt_n[i]   = '0;
                    end else begin
`ifdef KEY_EVENT_REPEAT_EN
                        // Restart from 0 so pulses stay exactly REP_CNT apart.
                        if (cnt_q[i] == REP_LAST) begin
                            rep_n[i] = 1'b1;
                            cnt_n[i] = '0;
                        end else begin
                            cnt_n[i] = cnt_q[i] + CW'(1);
                        end
`else
                        cnt_n[i] = '0;
`endif
                    end
                end
                default: begin
                    state_n[i] = IDLE;
                    cnt_n[i]   = '0;
                end
            endcase
        end
    end

    // Registers for input history, FSM state, counters and pulse vectors.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shape_d <= '1;
            press_q <= '0;
            rel_q   <= '0;
            long_q  <= '0;
            rep_q   <= '0;
            for (int i = 0; i < KEY_W; i++) begin
                state_q[i] <= IDLE;
                cnt_q[i]   <= '0;
            end
        end else begin
            shape_d <= bus.shape;
            press_q <= press_n;
            rel_q   <= rel_n;
            long_q  <= long_n;
            rep_q   <= rep_n;
            for (int i = 0; i < KEY_W; i++) begin
                state_q[i] <= state_n[i];
                cnt_q[i]   <= cnt_n[i];
            end
        end
    end

    // Priority encoder: lowest key wins, press > long > repeat > release.
    always_comb begin
        enc_vld  = 1'b0;
        enc_key  = '0;
        enc_type = 2'd0;
        for (int i = KEY_W - 1; i >= 0; i--) begin
            if (press_q[i] || long_q[i] || rep_q[i] || rel_q[i]) begin
                enc_vld = 1'b1;
                enc_key = 3'(i);
                if (press_q[i])     enc_type = 2'd0;
                else if (long_q[i]) enc_type = 2'd2;
                else if (rep_q[i])  enc_type = 2'd3;
                else                enc_type = 2'd1;
            end
        end
    end

    // Encoded event register: lags the bit vectors by one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            evt_vld_q  <= 1'b0;
            evt_key_q  <= '0;
            evt_type_q <= '0;
        end else begin
            evt_vld_q  <= enc_vld;
            evt_key_q  <= enc_key;
            evt_type_q <= enc_type;
        end
    end

    // Output drive: held level and debug state come straight from the FSMs.
    always_comb begin
        bus.held      = '0;
        bus.dbg_state = '0;
        for (int i = 0; i < KEY_W; i++) begin
            bus.held[i]            = (state_q[i] != IDLE);
            bus.dbg_state[2*i +: 2] = state_q[i];
        end
    end

    assign bus.press       = press_q;
    assign bus.key_release = rel_q;
    assign bus.long_press  = long_q;
    assign bus.key_repeat  = rep_q;
    assign bus.evt_vld     = evt_vld_q;
    assign bus.evt_key     = evt_key_q;
    assign bus.evt_type    = evt_type_q;
endmodule

// File: tb/tb_key_event.sv
`timescale 1ns/1ps
// tb_key_event: directed bench for key_event with LONG_CNT=10, REP_CNT=4.
// Expected auto-repeat pulses follow KEY_EVENT_REPEAT_EN as seen by the bench.
module tb_key_event;
`ifdef KEY_EVENT_REPEAT_EN
    localparam bit REP_ON = 1'b1;
`else
    localparam bit REP_ON = 1'b0;
`endif

    logic clk;
    logic rst;
    int   total;
    int   bad;

    key_event_if #(.KEY_W(6)) bus ();

    key_event #(
        .KEY_W    (6),
        .LONG_CNT (10),
        .REP_CNT  (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Clock: 10 ns period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 ns past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // All outputs zero (reset state).
    task automatic chk_zero(input string tag);
        chk({tag, "_press"}, 32'(bus.press), 32'h0);
        chk({tag, "_release"}, 32'(bus.key_release), 32'h0);
        chk({tag, "_long"}, 32'(bus.long_press), 32'h0);
        chk({tag, "_repeat"}, 32'(bus.key_repeat), 32'h0);
        chk({tag, "_held"}, 32'(bus.held), 32'h0);
        chk({tag, "_evt_vld"}, 32'(bus.evt_vld), 32'h0);
        chk({tag, "_evt_key"}, 32'(bus.evt_key), 32'h0);
        chk({tag, "_evt_type"}, 32'(bus.evt_type), 32'h0);
    endtask

    task automatic chk_evt(input string tag, input logic vld, input logic [2:0] key,
                           input logic [1:0] typ);
        chk({tag, "_evt_vld"}, 32'(bus.evt_vld), 32'(vld));
        if (vld) begin
            chk({tag, "_evt_key"}, 32'(bus.evt_key), 32'(key));
            chk({tag, "_evt_type"}, 32'(bus.evt_type), 32'(typ));
        end
    endtask

    initial begin
        logic       ev;
        logic [1:0] et;
        total     = 0;
        bad       = 0;
        rst       = 1'b1;
        bus.shape = 6'h3f;

        // Reset state
        tick();
        tick();
        chk_zero("rst");
        rst = 1'b0;
        tick();
        chk_zero("idle");

        // Key 0: three-cycle tap, no long press
        bus.shape = 6'b111110;
        tick();                                       // edge k
        chk("t1_press", 32'(bus.press), 32'h01);
        chk("t1_held_k", 32'(bus.held), 32'h01);
        chk("t1_evt_lag", 32'(bus.evt_vld), 32'h0);
        tick();                                       // k+1
        chk("t1_press_gone", 32'(bus.press), 32'h00);
        chk_evt("t1_p", 1'b1, 3'd0, 2'd0);
        tick();                                       // k+2
        chk("t1_held_k2", 32'(bus.held), 32'h01);
        chk("t1_long_k2", 32'(bus.long_press), 32'h00);
        bus.shape = 6'h3f;
        tick();                                       // k+3 samples release
        chk("t1_release", 32'(bus.key_release), 32'h01);
        chk("t1_held_off", 32'(bus.held), 32'h00);
        chk("t1_long_k3", 32'(bus.long_press), 32'h00);
        tick();                                       // k+4
        chk("t1_release_gone", 32'(bus.key_release), 32'h00);
        chk_evt("t1_r", 1'b1, 3'd0, 2'd1);
        tick();

        // Key 2: 20-cycle hold -> press, long at k+9, repeats at k+13/k+17, release
        bus.shape = 6'b111011;
        for (int j = 0; j <= 21; j++) begin
            tick();                                   // edge k+j
            if (j == 19) bus.shape = 6'h3f;
            chk("t2_press", 32'(bus.press), (j == 0) ? 32'h04 : 32'h0);
            chk("t2_long", 32'(bus.long_press), (j == 9) ? 32'h04 : 32'h0);
            chk("t2_repeat", 32'(bus.key_repeat),
                (REP_ON && (j == 13 || j == 17)) ? 32'h04 : 32'h0);
            chk("t2_release", 32'(bus.key_release), (j == 20) ? 32'h04 : 32'h0);
            chk("t2_held", 32'(bus.held), (j < 20) ? 32'h04 : 32'h0);
            ev = 1'b0;
            et = 2'd0;
            if (j == 1) begin
                ev = 1'b1; et = 2'd0;
            end else if (j == 10) begin
                ev = 1'b1; et = 2'd2;
            end else if (REP_ON && (j == 14 || j == 18)) begin
                ev = 1'b1; et = 2'd3;
            end else if (j == 21) begin
                ev = 1'b1; et = 2'd1;
            end
            chk_evt("t2", ev, 3'd2, et);
        end
        tick();

        // Key 1: release sampled exactly on edge k+9 -> release, no long
        bus.shape = 6'b111101;
        for (int j = 0; j <= 10; j++) begin
            tick();
            if (j == 8) bus.shape = 6'h3f;
            chk("t3_press", 32'(bus.press), (j == 0) ? 32'h02 : 32'h0);
            chk("t3_long", 32'(bus.long_press), 32'h0);
            chk("t3_release", 32'(bus.key_release), (j == 9) ? 32'h02 : 32'h0);
            chk("t3_held", 32'(bus.held), (j < 9) ? 32'h02 : 32'h0);
        end
        tick();

        // Keys 3 and 5 pressed together: encoder reports key 3 only
        bus.shape = 6'b010111;
        tick();
        chk("t4_press", 32'(bus.press), 32'h28);
        chk("t4_held", 32'(bus.held), 32'h28);
        tick();
        chk_evt("t4_p", 1'b1, 3'd3, 2'd0);
        tick();
        chk("t4_evt_dropped", 32'(bus.evt_vld), 32'h0);
        bus.shape = 6'h3f;
        tick();
        chk("t4_release", 32'(bus.key_release), 32'h28);
        tick();
        chk_evt("t4_r", 1'b1, 3'd3, 2'd1);
        tick();
        chk("t4_evt_idle", 32'(bus.evt_vld), 32'h0);

        // Key 4: reset while long_press is pulsing, then re-press after reset
        bus.shape = 6'b101111;
        for (int j = 0; j <= 9; j++) tick();
        chk("t5_long", 32'(bus.long_press), 32'h10);
        chk("t5_state_long", 32'(bus.dbg_state[9:8]), 32'h2);
        rst = 1'b1;
        #1;
        chk_zero("t5_async");
        chk("t5_state_idle", 32'(bus.dbg_state), 32'h0);
        tick();
        chk_zero("t5_in_rst");
        rst = 1'b0;
        tick();
        chk("t5_repress", 32'(bus.press), 32'h10);
        chk("t5_held", 32'(bus.held), 32'h10);
        tick();
        chk_evt("t5_p", 1'b1, 3'd4, 2'd0);
        bus.shape = 6'h3f;
        tick();
        chk("t5_release", 32'(bus.key_release), 32'h10);
        chk("t5_held_off", 32'(bus.held), 32'h00);
        tick();
        chk_evt("t5_r", 1'b1, 3'd4, 2'd1);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
